// File: rtl/memory_load_unit.sv
// memory_load_unit
//   Issues one aligned word read to the data RAM per load request and returns
//   the addressed byte, half word or word right-justified in Out. Requests are
//   checked for size/alignment before any RAM access. A request that is never
//   answered by MFC is abandoned after TIMEOUT cycles.
//
// Ports
//   Clk       rising-edge clock
//   CLR       asynchronous active-high reset
//   start     load request, only looked at while idle
//   addr      byte address of the load
//   dataSize  00 byte, 01 half word, 10 word, 11 illegal
//   busy      high in every state except IDLE
//   memAddr   word-aligned address presented to the data RAM
//   MOV       read request to the data RAM (high only while waiting)
//   MFC       read complete from the data RAM
//   memData   read word, valid when MFC is high
//   Out       loaded data, right-justified, upper bits zero
//   outSize   size of the value currently in Out
//   done      one-cycle pulse, Out/outSize valid
//   alignErr  one-cycle pulse, misaligned or illegal request
//   timeout   one-cycle pulse, MFC never arrived
module memory_load_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        CLR,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  dataSize,
  output logic        busy,
  output logic [31:0] memAddr,
  output logic        MOV,
  input  logic        MFC,
  input  logic [31:0] memData,
  output logic [31:0] Out,
  output logic [1:0]  outSize,
  output logic        done,
  output logic        alignErr,
  output logic        timeout
);

  // Wide enough to hold TIMEOUT-1, the last count before giving up.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_t;

  state_t          state;
  state_t          nextState;
  logic [1:0]      offReg;
  logic [1:0]      sizeReg;
  logic [CW-1:0]   waitCnt;
  logic            errIsTimeout;
  logic            reqLegal;
  logic            lastWait;
  logic [31:0]     laneData;

  // Byte loads may sit at any offset, halves must not straddle a half-word
  // boundary, words must be word aligned, and size 11 is never legal.
  always_comb begin
    reqLegal = 1'b0;
    case (dataSize)
      2'b00:   reqLegal = 1'b1;
      2'b01:   reqLegal = ~addr[0];
      2'b10:   reqLegal = (addr[1:0] == 2'b00);
      default: reqLegal = 1'b0;
    endcase
  end

  assign lastWait = (waitCnt == CW'(TIMEOUT - 1));

  // Little-endian lane select using the offset and size latched at start.
  // Size 11 is never latched, so the default branch only serves the word case.
  always_comb begin
    laneData = memData;
    case (sizeReg)
      2'b00:   laneData = {24'b0, memData[{offReg, 3'b000} +: 8]};
      2'b01:   laneData = {16'b0, memData[{offReg[1], 4'b0000} +: 16]};
      default: laneData = memData;
    endcase
  end

  // State register; CLR abandons any transaction in flight, and because MOV
  // is decoded from the state it drops in the same cycle.
  always_ff @(posedge Clk or posedge CLR) begin
    if (CLR) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and output decode. In WAIT, MFC takes priority over the
  // timeout so a reply on the final allowed cycle still completes the load.
  always_comb begin
    nextState = state;
    busy      = 1'b1;
    MOV       = 1'b0;
    done      = 1'b0;
    alignErr  = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          nextState = reqLegal ? WAIT : ERR;
        end
      end
      WAIT: begin
        MOV = 1'b1;
        if (MFC) begin
          nextState = DONE;
        end else if (lastWait) begin
          nextState = ERR;
        end
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      ERR: begin
        alignErr  = ~errIsTimeout;
        timeout   = errIsTimeout;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Datapath registers. Out and outSize only change when a load completes or
  // fails, so they hold their value while idle. Out is cleared on the way
  // into ERR so a failed load never leaves stale data looking valid.
  always_ff @(posedge Clk or posedge CLR) begin
    if (CLR) begin
      offReg       <= 2'b00;
      sizeReg      <= 2'b00;
      memAddr      <= 32'h0;
      waitCnt      <= '0;
      errIsTimeout <= 1'b0;
      Out          <= 32'h0;
      outSize      <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (start && reqLegal) begin
            offReg  <= addr[1:0];
            sizeReg <= dataSize;
            memAddr <= {addr[31:2], 2'b00};
            waitCnt <= '0;
          end else if (start) begin
            errIsTimeout <= 1'b0;
            Out          <= 32'h0;
          end
        end
        WAIT: begin
          if (MFC) begin
            Out     <= laneData;
            outSize <= sizeReg;
          end else if (lastWait) begin
            errIsTimeout <= 1'b1;
            Out          <= 32'h0;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/memory_load_unit.md
MEMORY_LOAD_UNIT -- requirements
Module: memory_load_unit

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the max cycles WAIT holds MOV without MFC before aborting.
REQ-002 Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 CLR  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  load request, sampled only in IDLE.
REQ-005 addr  input  32  byte address of the load.
REQ-006 dataSize  input  2  encoding: 00 byte, 01 half word, 10 word, 11 illegal.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 memAddr  output  32  word-aligned address to data RAM.
REQ-009 MOV  output  1  memory operation valid (read request) to data RAM.
REQ-010 MFC  input  1  memory function complete from data RAM.
REQ-011 memData  input  32  read word from data RAM, valid when MFC high.
REQ-012 Out  output  32  loaded data, right-justified, upper bits zero; feeds signExtension In.
REQ-013 outSize  output  2  size of the current Out; feeds signExtension dataSize.
REQ-014 done  output  1  one-cycle pulse: Out/outSize valid.
REQ-015 alignErr  output  1  one-cycle pulse: misaligned or illegal request.
REQ-016 timeout  output  1  one-cycle pulse: MFC never arrived.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, DONE, ERR.
REQ-018 IDLE: start=1 with legal, aligned request SHALL latch addr[1:0] and dataSize, drive memAddr={addr[31:2],2'b00}, clear the timeout counter, and go to WAIT.
REQ-019 Alignment rules: byte any offset; half offset 0 or 2; word offset 0; dataSize 11 always illegal.
REQ-020 IDLE: start=1 with illegal/misaligned request SHALL go to ERR without asserting MOV.
REQ-021 WAIT: MOV SHALL be 1; MOV SHALL be 0 in every other state.
REQ-022 WAIT: MFC=1 SHALL capture lane-selected memData into Out, set outSize, go to DONE.
REQ-023 Lane select (little-endian): byte Out={24'b0, memData[8*off+7:8*off]}; half Out={16'b0, memData[16*off[1]+15:16*off[1]]}; word Out=memData.
REQ-024 WAIT: counter SHALL increment each cycle without MFC; MFC absent on the cycle counter equals TIMEOUT-1 SHALL go to ERR with timeout flag set.
REQ-025 MFC on the same cycle as timeout expiry SHALL win: capture data, go to DONE, no timeout.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 ERR: exactly one of alignErr or timeout SHALL pulse one cycle, Out SHALL be 32'h0, then IDLE.
REQ-028 start while busy SHALL be ignored; no queuing.
REQ-029 Out, outSize SHALL hold their values between transactions.
REQ-030 Load latency: start edge to done pulse SHALL be 2 cycles plus MFC wait cycles (MFC high first WAIT cycle -> done 2 cycles after start).
REQ-031 MFC outside WAIT SHALL be ignored.

Reset
REQ-032 CLR=1 SHALL immediately force IDLE, Out=0, outSize=00, memAddr=0, counter=0, MOV=busy=done=alignErr=timeout=0.
REQ-033 CLR asserted mid-WAIT SHALL drop MOV asynchronously and discard the transaction; no done or timeout pulse follows.
REQ-034 First start after CLR release SHALL be accepted on the next rising edge.

Verification
REQ-035 Byte load: addr=0x103, size 00, MFC after 3 cycles, memData=0xA1B2C3D4 -> memAddr=0x100, Out=0x000000A1, outSize=00, done one pulse.
REQ-036 Half load: addr=0x202, size 01, memData=0x8765_4321 -> Out=0x00008765, outSize=01; addr=0x201 size 01 -> alignErr pulse, MOV never high.
REQ-037 Word load: addr=0x40, size 10, MFC first WAIT cycle, memData=0xDEADBEEF -> Out=0xDEADBEEF, done 2 cycles after start.
REQ-038 Timeout: TIMEOUT=15, MFC held 0 -> MOV high exactly 15 cycles, timeout pulse, Out=0, back to IDLE; MFC on cycle 15 -> done, no timeout.
REQ-039 Reset mid-op: CLR pulse during WAIT -> MOV=0 same cycle, all outputs 0, no done; start during busy -> ignored.
REQ-040 Chain with signExtension (E=1): byte 0x80 at offset 0 -> extended 0xFFFFFF80.
